// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and flag bundle shared by the ALU pipeline
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_XNOR  = 4'd0,
        ALU_SGE   = 4'd1,
        ALU_SGT   = 4'd2,
        ALU_SLL   = 4'd3,
        ALU_PASSB = 4'd4,
        ALU_SRL   = 4'd5,
        ALU_SNE   = 4'd6,
        ALU_NOR   = 4'd7,
        ALU_ADD   = 4'd8,
        ALU_SUB   = 4'd9,
        ALU_SRA   = 4'd10
    } alu_op_e;

    localparam int ALU_NUM_OPS = 11;

    typedef struct packed {
        logic carry;
        logic zero;
        logic overflow;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath producing result and flag bundle
//
// Ports:
//   opcode_i  operation select (values >= ALU_NUM_OPS are illegal)
//   a_i, b_i  operands A and B
//   sh_i      shift amount for SLL/SRL/SRA
//   result_o  operation result
//   flags_o   {carry, zero, overflow, illegal}
module alu_core
    import alu_pkg::*;
#(
    parameter  int WIDTH = 128,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       opcode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [SHW-1:0]   sh_i,
    output logic [WIDTH-1:0] result_o,
    output alu_flags_t       flags_o
);

    alu_op_e                 op;
    logic [WIDTH:0]          sum;
    logic [WIDTH:0]          diff;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        res;
    logic                    carry;
    logic                    ovf;
    logic                    ill;

    assign op   = alu_op_e'(opcode_i);
    assign a_s  = a_i;
    assign b_s  = b_i;
    // One extra bit captures the carry out of ADD and the borrow out of SUB.
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        ill   = 1'b0;
        case (op)
            ALU_XNOR:  res = ~(a_i ^ b_i);
            ALU_SGE:   res = {{(WIDTH-1){1'b0}}, (a_s >= b_s)};
            ALU_SGT:   res = {{(WIDTH-1){1'b0}}, (a_s > b_s)};
            ALU_SLL:   res = a_i << sh_i;
            ALU_PASSB: res = b_i;
            ALU_SRL:   res = a_i >> sh_i;
            ALU_SNE:   res = {{(WIDTH-1){1'b0}}, (a_i != b_i)};
            ALU_NOR:   res = ~(a_i | b_i);
            ALU_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                        (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SUB: begin
                res   = diff[WIDTH-1:0];
                // Carry means "no borrow", i.e. A >= B unsigned.
                carry = ~diff[WIDTH];
                ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                        (diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SRA:   res = a_s >>> sh_i;
            default:   ill = 1'b1;
        endcase
    end

    assign result_o         = res;
    assign flags_o.carry    = carry;
    assign flags_o.zero     = (res == '0);
    assign flags_o.overflow = ovf;
    assign flags_o.illegal  = ill;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready pipelined ALU
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        request handshake
//   opcode, input1, input2     operation select and operands A, B
//   shiftValue                 shift amount
//   out_valid / out_ready      result handshake
//   result                     operation result
//   carryFlag, zeroFlag,
//   overFlowFlag, illegalOp    result flags
module alu_pipe
    import alu_pkg::*;
#(
    parameter  int WIDTH = 128,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [SHW-1:0]   shiftValue,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryFlag,
    output logic             zeroFlag,
    output logic             overFlowFlag,
    output logic             illegalOp
);

    // Stage 1: registered request
    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [SHW-1:0]   s1_sh_q;

    // Stage 2: registered result
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    alu_flags_t       s2_flags_q, s2_flags_d;

    logic             s1_advance;
    logic             s2_advance;
    logic             s1_load;

    logic [WIDTH-1:0] core_result;
    alu_flags_t       core_flags;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .opcode_i (s1_op_q),
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .sh_i     (s1_sh_q),
        .result_o (core_result),
        .flags_o  (core_flags)
    );

    // A stage advances when it is empty or the stage after it advances;
    // in_valid never feeds back into in_ready.
    always_comb begin
        s2_advance  = !s2_valid_q || out_ready;
        s1_advance  = !s1_valid_q || s2_advance;
        s1_load     = s1_advance && in_valid;
        s1_valid_d  = s1_advance ? in_valid : s1_valid_q;

        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            // Only capture real data; a bubble leaves the old values in place.
            if (s1_valid_q) begin
                s2_result_d = core_result;
                s2_flags_d  = core_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
        end
    end

    // Stage-1 payload is qualified by s1_valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_op_q <= opcode;
            s1_a_q  <= input1;
            s1_b_q  <= input2;
            s1_sh_q <= shiftValue;
        end
    end

    assign in_ready     = s1_advance;
    assign out_valid    = s2_valid_q;
    assign result       = s2_result_q;
    assign carryFlag    = s2_flags_q.carry;
    assign zeroFlag     = s2_flags_q.zero;
    assign overFlowFlag = s2_flags_q.overflow;
    assign illegalOp    = s2_flags_q.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe at WIDTH=8
module tb_alu_pipe;

    localparam int W = 8;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    opcode;
    logic [W-1:0]  input1;
    logic [W-1:0]  input2;
    logic [SW-1:0] shiftValue;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          carryFlag;
    logic          zeroFlag;
    logic          overFlowFlag;
    logic          illegalOp;

    alu_pipe #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .input1       (input1),
        .input2       (input2),
        .shiftValue   (shiftValue),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .carryFlag    (carryFlag),
        .zeroFlag     (zeroFlag),
        .overFlowFlag (overFlowFlag),
        .illegalOp    (illegalOp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       v;
        logic       ill;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   occ = 0;
    int   drained = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: plain integer arithmetic on 8-bit values.
    function automatic exp_t model(input int op, input int a, input int b, input int sh);
        exp_t e;
        int   sa, sb, r, t;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        e = '0;
        r = 0;
        case (op)
            0:  r = (~(a ^ b)) & 255;
            1:  r = (sa >= sb) ? 1 : 0;
            2:  r = (sa > sb) ? 1 : 0;
            3:  r = (a << sh) & 255;
            4:  r = b;
            5:  r = a >> sh;
            6:  r = (a != b) ? 1 : 0;
            7:  r = (~(a | b)) & 255;
            8: begin
                r   = (a + b) & 255;
                e.c = (a + b) > 255;
                t   = sa + sb;
                e.v = (t > 127) || (t < -128);
            end
            9: begin
                r   = (a - b) & 255;
                e.c = (a >= b);
                t   = sa - sb;
                e.v = (t > 127) || (t < -128);
            end
            10: r = (sa >>> sh) & 255;
            default: e.ill = 1'b1;
        endcase
        e.res = r[7:0];
        e.z   = (r == 0);
        return e;
    endfunction

    // One clock: observe handshakes before the edge, update the scoreboard, advance.
    task automatic cycle(output bit acc);
        exp_t e;
        bit   drn;
        #1;
        chk("in_ready_rule", {31'b0, in_ready}, {31'b0, (out_ready || occ < 2)});
        acc = in_valid && in_ready;
        drn = 1'b0;
        if (out_valid) begin
            if (expq.size() == 0) begin
                chk("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                e = expq[0];
                chk("result",   {24'b0, result},            {24'b0, e.res});
                chk("carry",    {31'b0, carryFlag},         {31'b0, e.c});
                chk("zero",     {31'b0, zeroFlag},          {31'b0, e.z});
                chk("overflow", {31'b0, overFlowFlag},      {31'b0, e.v});
                chk("illegal",  {31'b0, illegalOp},         {31'b0, e.ill});
                if (out_ready) begin
                    void'(expq.pop_front());
                    drn = 1'b1;
                    drained++;
                end
            end
        end
        if (acc) begin
            expq.push_back(model(int'(opcode), int'(input1), int'(input2), int'(shiftValue)));
            occ++;
        end
        if (drn) occ--;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input int op, input int a, input int b,
                            input int sh, input int er, input bit ec, input bit ez,
                            input bit ev, input bit ei);
        bit acc;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        opcode     = op[3:0];
        input1     = a[7:0];
        input2     = b[7:0];
        shiftValue = sh[2:0];
        cycle(acc);
        chk({tag, "_accepted"}, {31'b0, acc}, 32'd1);
        in_valid = 1'b0;
        chk({tag, "_valid_n1"}, {31'b0, out_valid}, 32'd0);
        cycle(acc);
        chk({tag, "_valid_n2"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_res"},  {24'b0, result},       er);
        chk({tag, "_c"},    {31'b0, carryFlag},    {31'b0, ec});
        chk({tag, "_z"},    {31'b0, zeroFlag},     {31'b0, ez});
        chk({tag, "_v"},    {31'b0, overFlowFlag}, {31'b0, ev});
        chk({tag, "_ill"},  {31'b0, illegalOp},    {31'b0, ei});
        cycle(acc);
    endtask

    initial begin
        bit acc;
        int tries;
        int sc;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        opcode     = '0;
        input1     = '0;
        input2     = '0;
        shiftValue = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid},    32'd0);
        chk("rst_result",    {24'b0, result},       32'd0);
        chk("rst_carry",     {31'b0, carryFlag},    32'd0);
        chk("rst_zero",      {31'b0, zeroFlag},     32'd0);
        chk("rst_ovf",       {31'b0, overFlowFlag}, 32'd0);
        chk("rst_ill",       {31'b0, illegalOp},    32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        directed("add_ovf",   8, 8'h7F, 8'h01, 0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        directed("sub_zero",  9, 8'h05, 8'h05, 0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        directed("sub_borrow",9, 8'h03, 8'h05, 0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("sgt",       2, 8'h01, 8'hFF, 0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("sge",       1, 8'h80, 8'h7F, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        directed("sra",      10, 8'h80, 8'h00, 3, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("sll",       3, 8'h81, 8'h00, 1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("illegal",  13, 8'h12, 8'h34, 2, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        directed("after_ill", 8, 8'h10, 8'h20, 0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("sra_sh0",  10, 8'hA5, 8'h00, 0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random stream of 20 with a 5-cycle output stall in the middle.
        drained = 0;
        sc = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid   = 1'b1;
            opcode     = 4'($urandom_range(0, 15));
            input1     = 8'($urandom);
            input2     = 8'($urandom);
            shiftValue = 3'($urandom);
            acc   = 1'b0;
            tries = 0;
            while (!acc && tries < 20) begin
                out_ready = !(sc >= 6 && sc < 11);
                cycle(acc);
                sc++;
                tries++;
            end
            if (!acc) chk("stream_accept_timeout", 32'd0, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tries = 0;
        while (expq.size() != 0 && tries < 50) begin
            cycle(acc);
            tries++;
        end
        chk("stream_drain_empty", expq.size(), 32'd0);
        chk("stream_count", drained, 32'd20);
        chk("stream_idle_valid", {31'b0, out_valid}, 32'd0);

        // Reset with two requests in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid   = 1'b1;
            opcode     = 4'd8;
            input1     = 8'($urandom_range(1, 100));
            input2     = 8'h01;
            shiftValue = '0;
            cycle(acc);
        end
        in_valid = 1'b0;
        cycle(acc);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        chk("pre_rst_in_ready", {31'b0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid",  {31'b0, out_valid},    32'd0);
        chk("async_rst_result", {24'b0, result},       32'd0);
        chk("async_rst_carry",  {31'b0, carryFlag},    32'd0);
        chk("async_rst_zero",   {31'b0, zeroFlag},     32'd0);
        chk("async_rst_ovf",    {31'b0, overFlowFlag}, 32'd0);
        chk("async_rst_ill",    {31'b0, illegalOp},    32'd0);
        expq.delete();
        occ = 0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
            chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
            cycle(acc);
        end
        directed("post_rst_add", 8, 8'hFF, 8'h01, 0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined successor to the team's generated combinational ALUs. It generalises operand width, implements every comparison opcode with defined results, and computes carry, zero and overflow flags for all operations. It adds a valid/ready handshake with full backpressure, so it can sit between a request FIFO and a writeback stage in the generated-datapath flow.

## Interface
- `WIDTH`, 128: operand and result width; must be a power of two, ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; not overridden).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept the request this cycle.
- `opcode`  in  4  operation select.
- `input1`  in  WIDTH  operand A.
- `input2`  in  WIDTH  operand B.
- `shiftValue`  in  SHW  shift amount.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  operation result.
- `carryFlag`  out  1  carry / no-borrow.
- `zeroFlag`  out  1  result == 0.
- `overFlowFlag`  out  1  signed overflow.
- `illegalOp`  out  1  opcode not in the defined set.

## Operation
- Opcodes:
  - 0 XNOR: ~(A^B).
  - 1 SGE: signed A≥B.
  - 2 SGT: signed A>B.
  - 3 SLL: A<<sh.
  - 4 PASSB: B.
  - 5 SRL: A>>sh.
  - 6 SNE: A≠B.
  - 7 NOR: ~(A|B).
  - 8 ADD: A+B.
  - 9 SUB: A−B.
  - 10 SRA: A>>>sh (sign fill).
  - 11–15: illegal.
- Compares (SGE/SGT/SNE): result = {WIDTH-1 zeros, cmp bit}.
- carryFlag:
  - ADD: bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: 1 when no borrow (A ≥ B unsigned).
  - All other opcodes: 0.
- overFlowFlag:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from A.
  - All other opcodes: 0.
- zeroFlag: result == 0 for every opcode, including compares and illegal.
- Illegal opcode: result = 0, carryFlag = 0, overFlowFlag = 0, zeroFlag = 1, illegalOp = 1. The request still flows through the pipeline; it is never dropped.
- Shift amounts are 0..WIDTH-1; a shift of 0 returns A unchanged.

## Timing
- Stage 1 registers opcode, operands and shiftValue. Stage 2 registers result, flags and illegalOp.
- Latency: a request accepted in cycle N (in_valid & in_ready) shows out_valid = 1 in cycle N+2 when out_ready has been high throughout.
- Throughput: one request per cycle with no stalls.
- Stage k advances when it is empty or stage k+1 advances. in_ready = !s1_valid | s1_advance. This is combinational from out_ready, with no combinational path from in_valid.
- Stall (out_valid & !out_ready): result, flags and illegalOp hold stable. Stage 1 holds when full. in_ready falls once both stages are full.
- Simultaneous accept at the input and drain at the output in the same cycle: both take effect; no bubble is inserted and no data is lost.
- Reset (asynchronous, any time, including mid-operation):
  - s1_valid = 0, out_valid = 0, result = 0.
  - carryFlag = 0, zeroFlag = 0, overFlowFlag = 0, illegalOp = 0.
  - In-flight requests are discarded.
  - in_ready = 1 from the first cycle after rst_n deasserts.
- Data registers other than the outputs need no reset; valid bits must be reset.

## Structure
- Package `alu_pkg`:
  - opcode localparams or enum (ALU_XNOR … ALU_SRA).
  - `ALU_NUM_OPS` = 11.
  - Flag-bundle struct {carry, zero, overflow, illegal}.
- Sub-module `alu_core`: purely combinational, parametrised by WIDTH, taking opcode/A/B/shift and producing result and the flag bundle. Instantiated between stage 1 and stage 2.
- `alu_pipe` contains only the pipeline registers, valid/ready control and reset.

## Test plan
All scenarios use WIDTH=8.
- ADD 0x7F+0x01 → result 0x80, overFlowFlag = 1, carryFlag = 0, zeroFlag = 0, out_valid in cycle N+2.
- SUB 0x05−0x05 → result 0x00, zeroFlag = 1, carryFlag = 1. SUB 0x03−0x05 → 0xFE, carryFlag = 0.
- SGT signed 0x01 vs 0xFF → result 0x01. SGE 0x80 vs 0x7F → result 0x00. SRA 0x80 by 3 → 0xF0. SLL 0x81 by 1 → 0x02.
- Opcode 13 → result 0x00, illegalOp = 1, zeroFlag = 1. The next legal request completes normally.
- Back-to-back stream of 20 random requests with out_ready held low for 5 cycles mid-stream:
  - in_ready drops after two accepts.
  - Outputs are stable during the stall.
  - All 20 results arrive in order, none lost or duplicated, and match a reference model.
- Assert rst_n low while two requests are in flight → all outputs 0 immediately (asynchronously). After release, out_valid stays 0 until a new request is accepted, and in_ready = 1.
